// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/NOP constants, PC step and the fetch FSM state type.
package cpu_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef logic [1:0] fetchState_t;
  localparam fetchState_t FS_IDLE  = 2'd0;
  localparam fetchState_t FS_FETCH = 2'd1;
  localparam fetchState_t FS_HOLD  = 2'd2;

  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_stall_counter.sv
// Saturating 32-bit count of cycles in which the PC was held by the hazard unit.
module if_stall_counter
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallCycle,
  output logic [31:0] count
);
  logic [31:0] countReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countReg <= 32'd0;
    end else if (stallCycle && (countReg != 32'hFFFF_FFFF)) begin
      countReg <= countReg + 32'd1;
    end
  end

  assign count = countReg;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, stall hold buffer and branch redirect.
// Optional StallCount output when IF_STALL_COUNT_EN is defined.
module if_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_Instr,
  output logic        IFID_Valid,
  output logic        FetchBusy
`ifdef IF_STALL_COUNT_EN
  ,
  output logic [31:0] StallCount
`endif
);
  fetchState_t stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [31:0] holdBufReg, holdBufNext;
  logic        redirPendReg, redirPendNext;
  logic [31:0] redirTgtReg, redirTgtNext;
  logic [31:0] ifidPcReg, ifidPcNext;
  logic [31:0] ifidInstrReg, ifidInstrNext;
  logic        ifidValidReg, ifidValidNext;
  logic        advance;

  assign advance = PCWrite && IFIDWrite;

  always_comb begin
    stateNext     = stateReg;
    pcNext        = pcReg;
    holdBufNext   = holdBufReg;
    redirPendNext = redirPendReg;
    redirTgtNext  = redirTgtReg;
    ifidPcNext    = ifidPcReg;
    ifidInstrNext = ifidInstrReg;
    ifidValidNext = ifidValidReg;

    // A redirect flushes IF/ID regardless of stall or state.
    if (BranchTaken) begin
      ifidInstrNext = NOP_INSTR;
      ifidValidNext = 1'b0;
    end

    case (stateReg)
      FS_IDLE: begin
        stateNext = FS_FETCH;
      end
      FS_FETCH: begin
        if (BranchTaken) begin
          if (ImemAck) begin
            pcNext        = alignPc(BranchTarget);
            redirPendNext = 1'b0;
          end else begin
            // Address must stay put until the in-flight word returns.
            redirPendNext = 1'b1;
            redirTgtNext  = alignPc(BranchTarget);
          end
        end else if (ImemAck) begin
          if (redirPendReg) begin
            pcNext        = redirTgtReg;
            redirPendNext = 1'b0;
            if (IFIDWrite) begin
              ifidInstrNext = NOP_INSTR;
              ifidValidNext = 1'b0;
            end
          end else if (advance) begin
            ifidPcNext    = pcReg;
            ifidInstrNext = ImemData;
            ifidValidNext = 1'b1;
            pcNext        = pcReg + PC_STEP;
          end else begin
            holdBufNext = ImemData;
            stateNext   = FS_HOLD;
          end
        end else if (IFIDWrite) begin
          ifidInstrNext = NOP_INSTR;
          ifidValidNext = 1'b0;
        end
      end
      FS_HOLD: begin
        if (BranchTaken) begin
          pcNext        = alignPc(BranchTarget);
          redirPendNext = 1'b0;
          stateNext     = FS_FETCH;
        end else if (advance) begin
          ifidPcNext    = pcReg;
          ifidInstrNext = holdBufReg;
          ifidValidNext = 1'b1;
          pcNext        = pcReg + PC_STEP;
          stateNext     = FS_FETCH;
        end
      end
      default: begin
        stateNext = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg     <= FS_IDLE;
      pcReg        <= RESET_PC;
      holdBufReg   <= 32'd0;
      redirPendReg <= 1'b0;
      redirTgtReg  <= 32'd0;
      ifidPcReg    <= 32'd0;
      ifidInstrReg <= NOP_INSTR;
      ifidValidReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      pcReg        <= pcNext;
      holdBufReg   <= holdBufNext;
      redirPendReg <= redirPendNext;
      redirTgtReg  <= redirTgtNext;
      ifidPcReg    <= ifidPcNext;
      ifidInstrReg <= ifidInstrNext;
      ifidValidReg <= ifidValidNext;
    end
  end

  assign ImemReq    = (stateReg == FS_FETCH);
  assign FetchBusy  = ImemReq;
  assign ImemAddr   = pcReg;
  assign IFID_PC    = ifidPcReg;
  assign IFID_Instr = ifidInstrReg;
  assign IFID_Valid = ifidValidReg;

`ifdef IF_STALL_COUNT_EN
  if_stall_counter uStallCounter (
    .clk        (clk),
    .rst        (rst),
    .stallCycle (!PCWrite),
    .count      (StallCount)
  );
`endif
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized traffic vs. a behavioural model.
// Define IF_STALL_COUNT_EN to also check StallCount.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCWrite = 1'b1;
  logic        IFIDWrite = 1'b1;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck = 1'b0;
  logic [31:0] ImemData = 32'd0;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_Instr;
  logic        IFID_Valid;
  logic        FetchBusy;
`ifdef IF_STALL_COUNT_EN
  logic [31:0] StallCount;
`endif

  int numCompared = 0;
  int numMismatched = 0;
  int cycleNum = 0;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .ImemReq      (ImemReq),
    .ImemAddr     (ImemAddr),
    .ImemAck      (ImemAck),
    .ImemData     (ImemData),
    .IFID_PC      (IFID_PC),
    .IFID_Instr   (IFID_Instr),
    .IFID_Valid   (IFID_Valid),
    .FetchBusy    (FetchBusy)
`ifdef IF_STALL_COUNT_EN
    ,
    .StallCount   (StallCount)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a fetcher that is either starting up, waiting on memory, or parked on a stalled word.
  bit          mStarted;
  bit          mParked;
  logic [31:0] mParkedWord;
  bit          mRedirect;
  logic [31:0] mRedirTgt;
  logic [31:0] mPc;
  logic [31:0] mIfPc;
  logic [31:0] mIfInstr;
  bit          mIfValid;
  longint      mStalls;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycleNum);
    end
  endtask

  function automatic logic [31:0] wordAt(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic modelReset();
    mStarted = 0; mParked = 0; mParkedWord = 0; mRedirect = 0; mRedirTgt = 0;
    mPc = 0; mIfPc = 0; mIfInstr = 0; mIfValid = 0; mStalls = 0;
  endtask

  task automatic checkOutputs();
    bit req;
    req = mStarted && !mParked;
    checkVal("imem_req", {31'd0, ImemReq}, {31'd0, req});
    checkVal("fetch_busy", {31'd0, FetchBusy}, {31'd0, req});
    checkVal("imem_addr", ImemAddr, mPc);
    checkVal("ifid_pc", IFID_PC, mIfPc);
    checkVal("ifid_instr", IFID_Instr, mIfInstr);
    checkVal("ifid_valid", {31'd0, IFID_Valid}, {31'd0, mIfValid});
`ifdef IF_STALL_COUNT_EN
    checkVal("stall_count", StallCount, (mStalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : mStalls[31:0]);
`endif
  endtask

  // One clock: check current outputs, apply inputs, advance the model, cross the edge.
  task automatic step(input bit pcw, input bit ifw, input bit br, input logic [31:0] tgt,
                      input bit ack, input logic [31:0] data);
    logic [31:0] tgtAligned;
    checkOutputs();
    PCWrite = pcw; IFIDWrite = ifw; BranchTaken = br; BranchTarget = tgt;
    ImemAck = ack; ImemData = data;
    tgtAligned = tgt & 32'hFFFF_FFFC;
    if (!pcw) mStalls++;
    if (br) begin mIfValid = 0; mIfInstr = 0; end
    if (!mStarted) begin
      mStarted = 1;
    end else if (mParked) begin
      if (br) begin
        mPc = tgtAligned; mParked = 0; mRedirect = 0;
      end else if (pcw && ifw) begin
        mIfPc = mPc; mIfInstr = mParkedWord; mIfValid = 1; mPc = mPc + 4; mParked = 0;
      end
    end else if (br) begin
      if (ack) begin mPc = tgtAligned; mRedirect = 0; end
      else begin mRedirect = 1; mRedirTgt = tgtAligned; end
    end else if (ack) begin
      if (mRedirect) begin
        mPc = mRedirTgt; mRedirect = 0;
        if (ifw) begin mIfValid = 0; mIfInstr = 0; end
      end else if (pcw && ifw) begin
        mIfPc = mPc; mIfInstr = data; mIfValid = 1; mPc = mPc + 4;
      end else begin
        mParked = 1; mParkedWord = data;
      end
    end else if (ifw) begin
      mIfValid = 0; mIfInstr = 0;
    end
    $display("cyc %0d pcw=%0d ifw=%0d br=%0d tgt=%h ack=%0d data=%h -> pc=%h ifid=(%h,%h,%0d)",
             cycleNum, pcw, ifw, br, tgt, ack, data, mPc, mIfPc, mIfInstr, mIfValid);
    @(posedge clk);
    #1;
    cycleNum++;
  endtask

  task automatic applyReset(input bit ackDuring);
    rst = 1'b1; ImemAck = ackDuring; ImemData = 32'hDEAD_BEEF;
    #1;
    modelReset();
    checkOutputs();
    @(posedge clk);
    #1;
    checkOutputs();
    rst = 1'b0;
    $display("cyc %0d reset applied (ack=%0d)", cycleNum, ackDuring);
  endtask

  initial begin
    modelReset();
    @(posedge clk);
    #1;
    applyReset(1'b1);

    // Back-to-back fetches
    step(1, 1, 0, 0, 1, 32'h99);
    step(1, 1, 0, 0, 1, 32'h11);
    checkVal("r30_addr1", ImemAddr, 32'h4);
    checkVal("r30_ifid_pc0", IFID_PC, 32'h0);
    checkVal("r30_ifid_instr0", IFID_Instr, 32'h11);
    step(1, 1, 0, 0, 1, 32'h22);
    checkVal("r30_ifid_pc1", IFID_PC, 32'h4);
    checkVal("r30_ifid_instr1", IFID_Instr, 32'h22);

    // Stall on an acked word at 0x8
    step(0, 0, 0, 0, 1, 32'h33);
    checkVal("r31_req_hold", {31'd0, ImemReq}, 32'd0);
    checkVal("r31_ifid_keep", IFID_Instr, 32'h22);
    step(0, 0, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 0, 32'h0);
    checkVal("r31_ifid_pc", IFID_PC, 32'h8);
    checkVal("r31_ifid_instr", IFID_Instr, 32'h33);
    checkVal("r31_pc", ImemAddr, 32'hC);

    // Redirect out of HOLD
    step(0, 1, 0, 0, 1, 32'h44);
    step(1, 1, 1, 32'h103, 0, 32'h0);
    checkVal("r32_valid", {31'd0, IFID_Valid}, 32'd0);
    checkVal("r32_addr", ImemAddr, 32'h100);
    step(1, 1, 0, 0, 1, 32'h66);
    checkVal("r32_no_held", IFID_Instr, 32'h66);

    // Redirect while the request to 0x10 is still outstanding
    step(1, 1, 1, 32'h10, 1, 32'h77);
    step(1, 1, 1, 32'h40, 0, 32'h0);
    step(1, 1, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 0, 32'h0);
    checkVal("r33_addr_stable", ImemAddr, 32'h10);
    step(1, 1, 0, 0, 1, 32'h55);
    checkVal("r33_addr", ImemAddr, 32'h40);
    checkVal("r33_discard", {31'd0, IFID_Valid}, 32'd0);

    // PC wrap-around
    step(1, 1, 1, 32'hFFFF_FFFF, 1, 32'h0);
    step(1, 1, 0, 0, 1, 32'h88);
    checkVal("r34_wrap", ImemAddr, 32'h0);
    checkVal("r34_ifid_pc", IFID_PC, 32'hFFFF_FFFC);

    // Reset mid-request with ack high, then 5 stall cycles
    step(1, 1, 0, 0, 0, 32'h0);
    applyReset(1'b1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 32'hAB);
    checkVal("r35_ifid_valid", {31'd0, IFID_Valid}, 32'd0);
`ifdef IF_STALL_COUNT_EN
    checkVal("r34_stall5", StallCount, 32'd5);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit pcw, ifw, br, ack;
      logic [31:0] tgt;
      if ($urandom_range(0, 199) == 0) applyReset($urandom_range(0, 1) == 1);
      pcw = ($urandom_range(0, 9) < 8);
      ifw = ($urandom_range(0, 9) < 8) || pcw && ($urandom_range(0, 1) == 1);
      br  = ($urandom_range(0, 99) < 7);
      tgt = $urandom;
      ack = ($urandom_range(0, 9) < 5);
      step(pcw, ifw, br, tgt, ack, ack ? wordAt(mPc) : $urandom);
    end
    checkOutputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end
endmodule
